iter_shifter: RTL and testbench



---
 rtl/iter_shifter_if.sv | 27 ++
 rtl/iter_shifter.sv | 100 ++++++++++
 tb/tb_iter_shifter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_shifter_if.sv
// Request/result bundle for the iterative shifter.
// master drives the request side, slave (the shifter) drives status and result.
interface iter_shifter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic             flush;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] shift_in;
  logic [CNT_W-1:0] shift_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shift_out;
  logic             carry_out;
  logic             zero;

  modport master (
    output start, flush, opcode, shift_in, shift_val,
    input  busy, done, shift_out, carry_out, zero
  );

  modport slave (
    input  start, flush, opcode, shift_in, shift_val,
    output busy, done, shift_out, carry_out, zero
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle SRL/ROL/SLL unit, one bit position per clock; done is valid shift_val+1 cycles after accept.
// Backpressure: start is ignored while busy; flush aborts any operation and suppresses done.
module iter_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  iter_shifter_if.slave sif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       op;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             accept;

  // A new op may enter in IDLE or in the DONE cycle, giving back-to-back issue.
  assign accept = sif.start && !sif.flush && (state != SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sif.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (sif.start) begin
            state_nxt = (sif.shift_val == '0) ? DONE : SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
        SHIFT: begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    sif.busy = (state == SHIFT);
    sif.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      op      <= 2'b00;
      cnt     <= '0;
    end else if (sif.flush) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      op      <= 2'b00;
      cnt     <= '0;
    end else if (accept) begin
      out_q   <= sif.shift_in;
      carry_q <= 1'b0;
      op      <= sif.opcode;
      cnt     <= sif.shift_val;
    end else if (state == SHIFT) begin
      cnt <= cnt - 1'b1;
      case (op)
        2'b00: begin
          out_q   <= {1'b0, out_q[WIDTH-1:1]};
          carry_q <= out_q[0];
        end
        2'b10: begin
          out_q   <= {out_q[WIDTH-2:0], 1'b0};
          carry_q <= out_q[WIDTH-1];
        end
        default: begin
          out_q   <= {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          carry_q <= out_q[WIDTH-1];
        end
      endcase
    end
  end

  assign sif.shift_out = out_q;
  assign sif.carry_out = carry_q;
  assign sif.zero      = (out_q == '0);

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed cases with literal results plus a
// randomized phase compared every cycle against a transaction-level shift model.
module tb_iter_shifter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   rand_rst;

  iter_shifter_if #(.WIDTH(16), .CNT_W(4)) sif ();

  iter_shifter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result of shifting x by k positions with the given opcode.
  function automatic logic [15:0] f_out(input logic [15:0] x, input logic [1:0] op, input int k);
    if (k == 0) return x;
    case (op)
      2'b00:   return x >> k;
      2'b10:   return x << k;
      default: return (x << k) | (x >> (16 - k));
    endcase
  endfunction

  // Last bit that left the word after k positions.
  function automatic logic f_carry(input logic [15:0] x, input logic [1:0] op, input int k);
    if (k == 0) return 1'b0;
    if (op == 2'b00) return x[k-1];
    return x[16-k];
  endfunction

  // Model: operand, opcode, amount and number of positions already shifted.
  logic [15:0] m_x;
  logic [1:0]  m_op;
  int          m_n;
  int          m_k;
  bit          m_busy;
  bit          m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x <= '0; m_op <= '0; m_n <= 0; m_k <= 0; m_busy <= 0; m_done <= 0;
    end else if (sif.flush) begin
      m_x <= '0; m_k <= 0; m_busy <= 0; m_done <= 0;
    end else if (!m_busy && sif.start) begin
      m_x    <= sif.shift_in;
      m_op   <= sif.opcode;
      m_n    <= int'(sif.shift_val);
      m_k    <= 0;
      m_busy <= (sif.shift_val != 0);
      m_done <= (sif.shift_val == 0);
    end else if (m_busy) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_n) begin
        m_busy <= 0;
        m_done <= 1;
      end
    end else begin
      m_done <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // The single per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n && !rand_rst) begin
      logic [15:0] eo;
      eo = f_out(m_x, m_op, m_k);
      chk("model_busy",  32'(sif.busy),      32'(m_busy));
      chk("model_done",  32'(sif.done),      32'(m_done));
      chk("model_out",   32'(sif.shift_out), 32'(eo));
      chk("model_carry", 32'(sif.carry_out), 32'(f_carry(m_x, m_op, m_k)));
      chk("model_zero",  32'(sif.zero),      32'(eo == 16'h0));
    end
  end

  task automatic wait_done(input string nm, output bit got, output int lat);
    got = 0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sif.done) begin
        got = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done, expected done within 40 cycles", nm);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [3:0] n);
    @(posedge clk); #2;
    sif.start = 1'b1; sif.opcode = op; sif.shift_in = x; sif.shift_val = n;
    @(posedge clk); #2;
    sif.start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [15:0] x,
                        input logic [3:0] n, input logic [15:0] eo, input logic ec, input int elat);
    bit got;
    int lat;
    issue(op, x, n);
    wait_done(nm, got, lat);
    if (got) begin
      chk({nm, "_lat"},   32'(lat),           32'(elat));
      chk({nm, "_out"},   32'(sif.shift_out), 32'(eo));
      chk({nm, "_carry"}, 32'(sif.carry_out), 32'(ec));
      chk({nm, "_zero"},  32'(sif.zero),      32'(eo == 16'h0));
    end
  endtask

  task automatic count_no_done(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sif.done) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_out"},   32'(sif.shift_out), 32'h0);
    chk({nm, "_zero"},  32'(sif.zero),      32'h1);
    chk({nm, "_busy"},  32'(sif.busy),      32'h0);
    chk({nm, "_done"},  32'(sif.done),      32'h0);
    chk({nm, "_carry"}, 32'(sif.carry_out), 32'h0);
  endtask

  initial begin
    bit got;
    int lat;
    vectors = 0; miscompares = 0; rand_rst = 0;
    rst_n = 1'b0;
    sif.start = 0; sif.flush = 0; sif.opcode = 0; sif.shift_in = 0; sif.shift_val = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    run_op("srl_8001_4",  2'b00, 16'h8001, 4'd4,  16'h0800, 1'b0, 5);
    run_op("srl_ffff_15", 2'b00, 16'hFFFF, 4'd15, 16'h0001, 1'b1, 16);
    run_op("rol_8001_1",  2'b01, 16'h8001, 4'd1,  16'h0003, 1'b1, 2);
    run_op("rol11_1234",  2'b11, 16'h1234, 4'd4,  16'h2341, 1'b1, 5);
    run_op("sll_c000_2",  2'b10, 16'hC000, 4'd2,  16'h0000, 1'b1, 3);
    run_op("sll_00ff_8",  2'b10, 16'h00FF, 4'd8,  16'hFF00, 1'b0, 9);
    for (int o = 0; o < 4; o++)
      run_op("zero_shift", 2'(o), 16'hA5A5, 4'd0, 16'hA5A5, 1'b0, 1);

    // start pulsed mid-shift must not disturb the op in flight
    issue(2'b00, 16'h8001, 4'd4);
    #1 sif.start = 1'b1; sif.opcode = 2'b10; sif.shift_in = 16'hFFFF; sif.shift_val = 4'd3;
    @(posedge clk); #2 sif.start = 1'b0;
    wait_done("ignore_start", got, lat);
    if (got) begin
      chk("ignore_start_out", 32'(sif.shift_out), 32'h0800);
      chk("ignore_start_lat", 32'(lat), 32'd4);
    end
    count_no_done("ignore_start_no_extra", 8);

    // start held through the DONE cycle: second op follows with no gap
    @(posedge clk); #2;
    sif.start = 1; sif.opcode = 2'b10; sif.shift_in = 16'h0001; sif.shift_val = 4'd2;
    @(posedge clk); #2;
    sif.opcode = 2'b00; sif.shift_in = 16'h00F0; sif.shift_val = 4'd4;
    wait_done("b2b_first", got, lat);
    if (got) chk("b2b_first_out", 32'(sif.shift_out), 32'h0004);
    @(posedge clk); #2 sif.start = 0;
    @(negedge clk);
    chk("b2b_no_gap_busy", 32'(sif.busy), 32'h1);
    wait_done("b2b_second", got, lat);
    if (got) begin
      chk("b2b_second_out",   32'(sif.shift_out), 32'h000F);
      chk("b2b_second_carry", 32'(sif.carry_out), 32'h0);
    end

    // flush early in an SRL by 8
    issue(2'b00, 16'hFFFF, 4'd8);
    @(posedge clk); #2 sif.flush = 1'b1;
    @(posedge clk); #2 sif.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",  32'(sif.busy),      32'h0);
    chk("flush_out",   32'(sif.shift_out), 32'h0);
    chk("flush_carry", 32'(sif.carry_out), 32'h0);
    count_no_done("flush_no_done", 12);

    // flush and start together: nothing accepted
    @(posedge clk); #2;
    sif.start = 1; sif.flush = 1; sif.opcode = 2'b01; sif.shift_in = 16'h1234; sif.shift_val = 4'd3;
    @(posedge clk); #2 sif.start = 0; sif.flush = 0;
    @(negedge clk);
    chk("flush_start_busy", 32'(sif.busy), 32'h0);
    chk("flush_start_done", 32'(sif.done), 32'h0);
    count_no_done("flush_start_no_done", 6);

    // asynchronous reset in the middle of an SRL by 10
    issue(2'b00, 16'hFFFF, 4'd10);
    @(posedge clk); #2;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    @(posedge clk); #2 rst_n = 1'b1;
    count_no_done("mid_reset_no_done", 15);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if (rand_rst) begin
        rst_n = 1'b1;
        rand_rst = 0;
      end else if ($urandom_range(0, 499) == 0) begin
        rand_rst = 1;
        rst_n = 1'b0;
      end
      sif.start  = ($urandom_range(0, 2) == 0);
      sif.flush  = ($urandom_range(0, 24) == 0);
      sif.opcode = 2'($urandom_range(0, 3));
      sif.shift_in = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       sif.shift_val = 4'd0;
        1:       sif.shift_val = 4'd15;
        default: sif.shift_val = 4'($urandom_range(0, 15));
      endcase
    end
    @(posedge clk); #2;
    rst_n = 1'b1; rand_rst = 0; sif.start = 0; sif.flush = 0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
